multi_fetch: RTL and testbench

MULTI_FETCH -- requirements
Module: multi_fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/imem_bytes.sv | 32 +++
 rtl/multi_fetch.sv | 179 +++++++++++++++++
 tb/tb_multi_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the multi-issue instruction fetch block.
// Optional feature: FETCH_ALIGN_TRAP_EN adds the FAULT state.
package fetch_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
`ifdef FETCH_ALIGN_TRAP_EN
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
`else
    ST_DONE  = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/imem_bytes.sv
// Byte-wide instruction memory: one synchronous write port, NPORTS combinational read ports.
module imem_bytes #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned PC_W      = 8,
  parameter int unsigned NPORTS    = 8
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [PC_W-1:0]        i_waddr,
  input  logic [7:0]             i_wdata,
  input  logic [NPORTS*PC_W-1:0] i_raddr,
  output logic [NPORTS*8-1:0]    o_rdata
);

  logic [7:0] r_mem [MEM_BYTES];

  // Program load write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Parallel byte reads, one per port.
  always_comb begin
    o_rdata = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      o_rdata[p*8 +: 8] = r_mem[i_raddr[p*PC_W +: PC_W]];
    end
  end

endmodule

// File: rtl/multi_fetch.sv
// Multi-issue fetch unit: assembles ISSUE_W big-endian instructions per bundle.
// Optional feature: FETCH_ALIGN_TRAP_EN traps misaligned redirects into FAULT.
module multi_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ISSUE_W   = 2,
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned PC_W      = $clog2(MEM_BYTES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [PC_W-1:0]            load_addr,
  input  logic [7:0]                 load_data,
  input  logic [PC_W:0]              prog_end,
  input  logic                       start,
  input  logic                       ready,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic [INSTR_W*ISSUE_W-1:0] instr,
  output logic [ISSUE_W-1:0]         slot_valid,
`ifdef FETCH_ALIGN_TRAP_EN
  output logic                       finish,
  output logic                       fault
`else
  output logic                       finish
`endif
);

  localparam int unsigned NPORTS       = ISSUE_W * BYTES_PER_INSTR;
  localparam int unsigned BUNDLE_BYTES = NPORTS;
  localparam int unsigned CW           = PC_W + 2;

  fetch_state_t               r_state, w_state_nxt;
  logic [PC_W:0]              r_pc, w_pc_nxt;
  logic [INSTR_W*ISSUE_W-1:0] r_instr, w_instr_nxt, w_bundle;
  logic [ISSUE_W-1:0]         r_valid, w_valid_nxt, w_slot_ok;
  logic                       r_finish, w_finish_nxt;
`ifdef FETCH_ALIGN_TRAP_EN
  logic                       r_fault, w_fault_nxt;
`endif
  logic [NPORTS*PC_W-1:0]     w_raddr;
  logic [NPORTS*8-1:0]        w_rdata;
  logic                       w_we;

  assign w_we = load_en && (r_state == ST_IDLE);

  imem_bytes #(
    .MEM_BYTES (MEM_BYTES),
    .PC_W      (PC_W),
    .NPORTS    (NPORTS)
  ) u_imem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Byte addresses of the bundle at pc; out-of-range ones are masked by slot validity.
  always_comb begin
    w_raddr = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      w_raddr[p*PC_W +: PC_W] = r_pc[PC_W-1:0] + PC_W'(p);
    end
  end

  // Slot validity against program end and memory end, and big-endian assembly.
  always_comb begin
    w_slot_ok = '0;
    w_bundle  = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      w_slot_ok[i] = ((CW'(r_pc) + CW'(i*4 + 3)) < CW'(prog_end)) &&
                     ((CW'(r_pc) + CW'(i*4 + 3)) < CW'(MEM_BYTES));
      w_bundle[i*INSTR_W +: INSTR_W] = w_slot_ok[i] ?
        {w_rdata[(i*4+0)*8 +: 8], w_rdata[(i*4+1)*8 +: 8],
         w_rdata[(i*4+2)*8 +: 8], w_rdata[(i*4+3)*8 +: 8]} : NOP_INSTR;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_valid_nxt  = r_valid;
    w_finish_nxt = r_finish;
`ifdef FETCH_ALIGN_TRAP_EN
    w_fault_nxt  = r_fault;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_RUN;
          w_pc_nxt     = '0;
          w_instr_nxt  = '0;
          w_valid_nxt  = '0;
          w_finish_nxt = 1'b0;
        end
      end
      ST_RUN, ST_DONE: begin
        if (redirect) begin
          w_instr_nxt = '0;
          w_valid_nxt = '0;
`ifdef FETCH_ALIGN_TRAP_EN
          if (redirect_pc[1:0] != 2'b00) begin
            w_state_nxt  = ST_FAULT;
            w_fault_nxt  = 1'b1;
            w_finish_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_RUN;
            w_pc_nxt     = {1'b0, redirect_pc};
            w_finish_nxt = 1'b0;
          end
`else
          w_state_nxt  = ST_RUN;
          w_pc_nxt     = {1'b0, redirect_pc & ~PC_W'(3)};
          w_finish_nxt = 1'b0;
`endif
        end else if ((|r_valid) && !ready) begin
          // Hold the current bundle until downstream accepts it.
        end else if (r_state == ST_RUN) begin
          w_instr_nxt = w_bundle;
          w_valid_nxt = w_slot_ok;
          if (&w_slot_ok) begin
            w_pc_nxt = r_pc + (PC_W+1)'(BUNDLE_BYTES);
          end else begin
            w_finish_nxt = 1'b1;
            w_state_nxt  = ST_DONE;
          end
        end else begin
          w_instr_nxt = '0;
          w_valid_nxt = '0;
        end
      end
`ifdef FETCH_ALIGN_TRAP_EN
      ST_FAULT: begin
        w_instr_nxt = '0;
        w_valid_nxt = '0;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pc and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_valid  <= '0;
      r_finish <= 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
      r_fault  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_valid  <= w_valid_nxt;
      r_finish <= w_finish_nxt;
`ifdef FETCH_ALIGN_TRAP_EN
      r_fault  <= w_fault_nxt;
`endif
    end
  end

  assign instr      = r_instr;
  assign slot_valid = r_valid;
  assign finish     = r_finish;
`ifdef FETCH_ALIGN_TRAP_EN
  assign fault      = r_fault;
`endif

endmodule

// File: tb/tb_multi_fetch.sv
// Directed bench for multi_fetch (ISSUE_W=2, MEM_BYTES=256).
module tb_multi_fetch;

  localparam int unsigned PC_W = 8;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic [8:0]  prog_end;
  logic        start;
  logic        ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [63:0] instr;
  logic [1:0]  slot_valid;
  logic        finish;
`ifdef FETCH_ALIGN_TRAP_EN
  logic        fault;
`endif

  int asserts;
  int fails;

  multi_fetch #(.ISSUE_W(2), .MEM_BYTES(256), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_end    (prog_end),
    .start       (start),
    .ready       (ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .slot_valid  (slot_valid),
`ifdef FETCH_ALIGN_TRAP_EN
    .finish      (finish),
    .fault       (fault)
`else
    .finish      (finish)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    asserts++;
    if (instr !== 64'h0) begin fails++; $display("FAIL reset_instr got %h want 0", instr); end
    asserts++;
    if (slot_valid !== 2'b00) begin fails++; $display("FAIL reset_valid got %b want 00", slot_valid); end
    asserts++;
    if (finish !== 1'b0) begin fails++; $display("FAIL reset_finish got %b want 0", finish); end
`ifdef FETCH_ALIGN_TRAP_EN
    asserts++;
    if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", fault); end
`endif
    rst = 1'b0;
    #3;
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = 8'(i);
      load_data = 8'(i);
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic test_basic(input string tag);
    prog_end = 9'd16;
    ready    = 1'b1;
    pulse_start();
    asserts++;
    if (slot_valid !== 2'b00) begin fails++; $display("FAIL %s_latency got %b want 00", tag, slot_valid); end
    tick();
    asserts++;
    if (instr !== 64'h04050607_00010203 || slot_valid !== 2'b11)
      begin fails++; $display("FAIL %s_b1 got %h/%b want 0405060700010203/11", tag, instr, slot_valid); end
    tick();
    asserts++;
    if (instr !== 64'h0C0D0E0F_08090A0B || slot_valid !== 2'b11)
      begin fails++; $display("FAIL %s_b2 got %h/%b want 0c0d0e0f08090a0b/11", tag, instr, slot_valid); end
    asserts++;
    if (finish !== 1'b0) begin fails++; $display("FAIL %s_b2_finish got %b want 0", tag, finish); end
    tick();
    asserts++;
    if (instr !== 64'h0 || slot_valid !== 2'b00 || finish !== 1'b1)
      begin fails++; $display("FAIL %s_end got %h/%b/%b want 0/00/1", tag, instr, slot_valid, finish); end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    asserts++;
    if (slot_valid !== 2'b00 || finish !== 1'b1)
      begin fails++; $display("FAIL %s_done_start got %b/%b want 00/1", tag, slot_valid, finish); end
  endtask

  task automatic test_short_prog;
    do_reset();
    prog_end = 9'd12;
    ready    = 1'b1;
    pulse_start();
    tick();
    asserts++;
    if (slot_valid !== 2'b11) begin fails++; $display("FAIL short_b1 got %b want 11", slot_valid); end
    tick();
    asserts++;
    if (instr !== 64'h00000000_08090A0B || slot_valid !== 2'b01 || finish !== 1'b1)
      begin fails++; $display("FAIL short_b2 got %h/%b/%b want 0000000008090a0b/01/1", instr, slot_valid, finish); end
    tick();
    asserts++;
    if (slot_valid !== 2'b00 || finish !== 1'b1)
      begin fails++; $display("FAIL short_done got %b/%b want 00/1", slot_valid, finish); end
  endtask

  task automatic test_prog_end_zero;
    do_reset();
    prog_end = 9'd0;
    ready    = 1'b1;
    pulse_start();
    tick();
    asserts++;
    if (slot_valid !== 2'b00 || finish !== 1'b1 || instr !== 64'h0)
      begin fails++; $display("FAIL zero_end got %h/%b/%b want 0/00/1", instr, slot_valid, finish); end
  endtask

  task automatic test_hold;
    do_reset();
    prog_end = 9'd16;
    ready    = 1'b1;
    pulse_start();
    tick();
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      asserts++;
      if (instr !== 64'h04050607_00010203 || slot_valid !== 2'b11)
        begin fails++; $display("FAIL hold_c%0d got %h/%b want 0405060700010203/11", c, instr, slot_valid); end
    end
    ready = 1'b1;
    tick();
    asserts++;
    if (instr !== 64'h0C0D0E0F_08090A0B || slot_valid !== 2'b11)
      begin fails++; $display("FAIL hold_advance got %h/%b want 0c0d0e0f08090a0b/11", instr, slot_valid); end
  endtask

  task automatic test_redirect;
    do_reset();
    prog_end = 9'd16;
    ready    = 1'b1;
    pulse_start();
    tick();
    ready       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'd8;
    tick();
    redirect = 1'b0;
    asserts++;
    if (slot_valid !== 2'b00 || finish !== 1'b0)
      begin fails++; $display("FAIL redir_clear got %b/%b want 00/0", slot_valid, finish); end
    load_en   = 1'b1;
    load_addr = 8'd0;
    load_data = 8'hFF;
    tick();
    load_en = 1'b0;
    asserts++;
    if (instr !== 64'h0C0D0E0F_08090A0B || slot_valid !== 2'b11)
      begin fails++; $display("FAIL redir_target got %h/%b want 0c0d0e0f08090a0b/11", instr, slot_valid); end
    ready = 1'b1;
    tick();
    tick();
    asserts++;
    if (finish !== 1'b1) begin fails++; $display("FAIL redir_done got %b want 1", finish); end
    redirect    = 1'b1;
    redirect_pc = 8'd0;
    tick();
    redirect = 1'b0;
    asserts++;
    if (finish !== 1'b0 || slot_valid !== 2'b00)
      begin fails++; $display("FAIL redir_from_done got %b/%b want 0/00", finish, slot_valid); end
    tick();
    asserts++;
    if (instr !== 64'h04050607_00010203 || slot_valid !== 2'b11)
      begin fails++; $display("FAIL redir_refetch got %h/%b want 0405060700010203/11", instr, slot_valid); end
  endtask

  task automatic test_async_reset;
    do_reset();
    prog_end = 9'd16;
    ready    = 1'b1;
    pulse_start();
    tick();
    ready = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    asserts++;
    if (instr !== 64'h0 || slot_valid !== 2'b00 || finish !== 1'b0)
      begin fails++; $display("FAIL async_rst got %h/%b/%b want 0/00/0", instr, slot_valid, finish); end
    rst = 1'b0;
    tick();
    test_basic("restart");
  endtask

  task automatic test_mem_end;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_addr = 8'(248 + i);
      load_data = 8'(8'hA0 + i);
      tick();
    end
    load_en  = 1'b0;
    prog_end = 9'h100;
    ready    = 1'b1;
    pulse_start();
    redirect    = 1'b1;
    redirect_pc = 8'd248;
    tick();
    redirect = 1'b0;
    tick();
    asserts++;
    if (instr !== 64'hA4A5A6A7_A0A1A2A3 || slot_valid !== 2'b11)
      begin fails++; $display("FAIL memend_last got %h/%b want a4a5a6a7a0a1a2a3/11", instr, slot_valid); end
    tick();
    asserts++;
    if (slot_valid !== 2'b00 || finish !== 1'b1)
      begin fails++; $display("FAIL memend_nowrap got %b/%b want 00/1", slot_valid, finish); end
  endtask

  task automatic test_misaligned;
    do_reset();
    prog_end = 9'd16;
    ready    = 1'b1;
    pulse_start();
    tick();
    redirect    = 1'b1;
    redirect_pc = 8'd6;
    tick();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
    asserts++;
    if (fault !== 1'b1 || finish !== 1'b1 || slot_valid !== 2'b00)
      begin fails++; $display("FAIL trap_enter got %b/%b/%b want 1/1/00", fault, finish, slot_valid); end
    start       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 8'd0;
    tick();
    tick();
    tick();
    start    = 1'b0;
    redirect = 1'b0;
    asserts++;
    if (fault !== 1'b1 || slot_valid !== 2'b00)
      begin fails++; $display("FAIL trap_sticky got %b/%b want 1/00", fault, slot_valid); end
    do_reset();
    asserts++;
    if (fault !== 1'b0) begin fails++; $display("FAIL trap_rst got %b want 0", fault); end
`else
    asserts++;
    if (slot_valid !== 2'b00 || finish !== 1'b0)
      begin fails++; $display("FAIL mask_clear got %b/%b want 00/0", slot_valid, finish); end
    tick();
    asserts++;
    if (instr !== 64'h08090A0B_04050607 || slot_valid !== 2'b11)
      begin fails++; $display("FAIL mask_target got %h/%b want 08090a0b04050607/11", instr, slot_valid); end
    tick();
    asserts++;
    if (instr !== 64'h00000000_0C0D0E0F || slot_valid !== 2'b01 || finish !== 1'b1)
      begin fails++; $display("FAIL mask_tail got %h/%b/%b want 000000000c0d0e0f/01/1", instr, slot_valid, finish); end
`endif
  endtask

  initial begin
    asserts     = 0;
    fails       = 0;
    rst         = 1'b1;
    load_en     = 1'b0;
    load_addr   = 8'h0;
    load_data   = 8'h0;
    prog_end    = 9'd0;
    start       = 1'b0;
    ready       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h0;
    test_reset();
    test_basic("basic");
    test_short_prog();
    test_prog_end_zero();
    test_hold();
    test_redirect();
    test_async_reset();
    test_mem_end();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
